skid_buf: RTL

//  Two-entry valid/ready register slice (skid buffer) between a producer and a consumer.

---
 rtl/skid_buf.sv | 108 ++++++++++
 1 files changed

// File: rtl/skid_buf.sv
// Two-entry valid/ready register slice; in_rdy comes from registered state only. Optional stall counter: SKID_BUF_STALL_CNT_EN.
// Latency 1 cycle in->out, 1 word/cycle; under backpressure the second word parks in the skid register and in_rdy drops.
module skid_buf #(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_data,
   input  logic          stall_clr,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_fire;
   logic          out_fire;

   assign out_vld  = (state_q != EMPTY);
   assign in_rdy   = (state_q != FULL);
   assign out_data = main_q;
   assign in_fire  = in_vld & in_rdy;
   assign out_fire = out_vld & out_rdy;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         // encoding 3 is unreachable; fall back to EMPTY
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef SKID_BUF_STALL_CNT_EN
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if (out_vld && !out_rdy && (stall_cnt_q != {CW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   logic unused_stall_clr;
   assign unused_stall_clr = stall_clr;
   assign stall_cnt        = '0;
`endif

endmodule
